// File: rtl/gcd_arb_pkg.sv
// gcd_arb_pkg
// Shared definitions for the GCD request arbiter:
//   - default requester count and operand width
//   - 2-bit arbiter state encoding (IDLE, ISSUE, BUSY, RESP)
package gcd_arb_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int W_DEFAULT    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/gcd_req_arbiter_rr_priority_picker.sv
// rr_priority_picker
// Round-robin search over a request vector: the first set bit found when
// scanning rr_ptr_i, rr_ptr_i+1, ... (wrapping modulo NREQ) wins.
// Ports:
//   valid_i  [NREQ-1:0]  request vector
//   rr_ptr_i [IW-1:0]    position where the search starts (must be < NREQ)
//   grant_o  [NREQ-1:0]  one-hot winner (zero when nothing is requested)
//   idx_o    [IW-1:0]    binary index of the winner
//   any_o                at least one request present
module rr_priority_picker
    import gcd_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IW-1:0]   rr_ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    // One extra bit so rr_ptr + offset never overflows before the wrap.
    localparam logic [IW:0] NREQ_V = (IW+1)'(NREQ);

    logic [IW:0] pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, rr_ptr_i} + (IW+1)'(k);
            if (pos >= NREQ_V) begin
                pos = pos - NREQ_V;
            end
            if (!any_o && valid_i[pos[IW-1:0]]) begin
                any_o                 = 1'b1;
                idx_o                 = pos[IW-1:0];
                grant_o[pos[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_req_arbiter.sv
// gcd_req_arbiter
// Shares one external GCD unit between NREQ requesters. A round-robin
// winner is accepted in IDLE, its operands are handed to the GCD unit with
// a one-cycle start pulse (ISSUE), the arbiter waits for the unit (BUSY) and
// then presents the result to the owning requester until it is consumed
// (RESP). Only one request is in flight at a time.
//
// Optional build macro: GCD_ARB_ZERO_BYPASS_EN
//   When defined, a request with a zero operand skips the GCD unit and
//   answers directly with req_a | req_b (which equals the GCD in that case).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid [NREQ]      per-requester operand valid
//   req_a, req_b [NREQ*W] packed operands, slice i = [i*W +: W]
//   req_ready [NREQ]      one-hot accept (IDLE only)
//   resp_valid [NREQ]     one-hot result valid to the owner
//   resp_result [W]       shared result bus, zero when no result is shown
//   resp_taken [NREQ]     per-requester result consume
//   gcd_a, gcd_b [W]      operands to the GCD unit
//   gcd_input_available   start pulse to the GCD unit
//   gcd_result_rdy        GCD unit done
//   gcd_result [W]        GCD unit result
//   gcd_result_taken      releases the GCD unit
module gcd_req_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int W    = W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0] req_ready,
    output logic [NREQ-1:0] resp_valid,
    output logic [W-1:0]    resp_result,
    input  logic [NREQ-1:0] resp_taken,
    output logic [W-1:0]    gcd_a,
    output logic [W-1:0]    gcd_b,
    output logic            gcd_input_available,
    input  logic            gcd_result_rdy,
    input  logic [W-1:0]    gcd_result,
    output logic            gcd_result_taken
);

    localparam int IW = $clog2(NREQ);

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   id_q, id_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;

    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [W-1:0]    sel_a, sel_b;
    logic [IW-1:0]   rr_next;

    rr_priority_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .valid_i  (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (pick_grant),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    // Operand slices of the current round-robin winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    assign rr_next = (pick_idx == IW'(NREQ-1)) ? '0 : pick_idx + IW'(1);

    always_comb begin
        state_d             = state_q;
        rr_ptr_d            = rr_ptr_q;
        id_d                = id_q;
        a_d                 = a_q;
        b_d                 = b_q;
        res_d               = res_q;
        req_ready           = '0;
        resp_valid          = '0;
        resp_result         = '0;
        gcd_a               = '0;
        gcd_b               = '0;
        gcd_input_available = 1'b0;
        gcd_result_taken    = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = pick_grant;
                if (pick_any) begin
                    a_d      = sel_a;
                    b_d      = sel_b;
                    id_d     = pick_idx;
                    rr_ptr_d = rr_next;
`ifdef GCD_ARB_ZERO_BYPASS_EN
                    // gcd(x, 0) = x, so a zero operand needs no GCD run.
                    if ((sel_a == '0) || (sel_b == '0)) begin
                        res_d   = sel_a | sel_b;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                gcd_a               = a_q;
                gcd_b               = b_q;
                gcd_input_available = 1'b1;
                state_d             = BUSY;
            end
            BUSY: begin
                gcd_a = a_q;
                gcd_b = b_q;
                if (gcd_result_rdy) begin
                    res_d            = gcd_result;
                    gcd_result_taken = 1'b1;
                    state_d          = RESP;
                end
            end
            RESP: begin
                gcd_a            = a_q;
                gcd_b            = b_q;
                resp_valid[id_q] = 1'b1;
                resp_result      = res_q;
                // Only the owner can release the result.
                if (resp_taken[id_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs stay quiet for the whole reset cycle, not just after it.
        if (reset) begin
            req_ready           = '0;
            resp_valid          = '0;
            resp_result         = '0;
            gcd_a               = '0;
            gcd_b               = '0;
            gcd_input_available = 1'b0;
            gcd_result_taken    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
        end
    end

endmodule

// File: doc/gcd_req_arbiter.md
GCD_REQ_ARBITER -- requirements
Module: gcd_req_arbiter

Interface
REQ-001 SHALL have parameter: NREQ, 4, number of requesters (2..8).
REQ-002 SHALL have parameter: W, 16, operand/result width in bits.
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: req_valid  input  NREQ  per-requester operand valid.
REQ-006 SHALL have port: req_a, req_b  input  NREQ*W  packed per-requester operands, slice i = [i*W +: W].
REQ-007 SHALL have port: req_ready  output  NREQ  one-hot accept, at most one bit high.
REQ-008 SHALL have port: resp_valid  output  NREQ  one-hot result valid to owning requester.
REQ-009 SHALL have port: resp_result  output  W  shared result bus.
REQ-010 SHALL have port: resp_taken  input  NREQ  per-requester result consume.
REQ-011 SHALL have port: gcd_a, gcd_b  output  W  operands to shared GCD unit.
REQ-012 SHALL have port: gcd_input_available  output  1  start pulse to GCD unit.
REQ-013 SHALL have port: gcd_result_rdy  input  1  GCD unit done.
REQ-014 SHALL have port: gcd_result  input  W  GCD unit result.
REQ-015 SHALL have port: gcd_result_taken  output  1  release GCD unit.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, BUSY, RESP.
REQ-017 In IDLE, SHALL grant the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ; req_ready[grant]=1 combinationally that cycle; no valid -> req_ready=0.
REQ-018 On accept, SHALL latch req_a/req_b slice and owner id, set rr_ptr <= (grant+1) mod NREQ, go to ISSUE.
REQ-019 In ISSUE, SHALL drive gcd_input_available=1 for exactly one cycle, gcd_a/gcd_b = latched operands; next state BUSY.
REQ-020 gcd_a/gcd_b SHALL hold latched operands stable from ISSUE through RESP.
REQ-021 In BUSY, SHALL wait for gcd_result_rdy; on it, capture gcd_result, drive gcd_result_taken=1 that cycle only, go to RESP.
REQ-022 In RESP, SHALL drive resp_valid[id]=1 and resp_result=captured value, held until resp_taken[id]=1, then go to IDLE.
REQ-023 resp_taken bits of non-owners SHALL be ignored; req_ready SHALL be 0 in all states except IDLE.
REQ-024 Earliest next accept SHALL be the cycle after the RESP->IDLE transition (no overlap).
REQ-025 Latency, valid accept to resp_valid: 2 + GCD compute cycles + 1.
REQ-026 resp_result SHALL be 0 whenever resp_valid is 0.

Reset
REQ-027 On reset=1 at clk edge, SHALL go to IDLE, rr_ptr=0, latched operands/result/id=0, regardless of state.
REQ-028 During and after reset, req_ready, resp_valid, resp_result, gcd_a, gcd_b, gcd_input_available, gcd_result_taken SHALL be 0.
REQ-029 Reset mid-operation SHALL drop the in-flight request silently; no response issued.

Configuration
REQ-030 Macro GCD_ARB_ZERO_BYPASS_EN defined: accept with req_a==0 or req_b==0 SHALL skip ISSUE/BUSY, go IDLE->RESP, result = req_a|req_b, GCD unit not started.
REQ-031 Macro undefined: zero operands SHALL take the normal ISSUE/BUSY path.

Structure
REQ-032 Package gcd_arb_pkg SHALL hold state encoding constants (2-bit) and default NREQ/W.
REQ-033 Round-robin search SHALL be a sub-module rr_priority_picker (inputs valid vector, rr_ptr; outputs one-hot grant, index, any).

Verification
REQ-034 Req0 (48,18), resp_taken same cycle -> resp_valid[0] with resp_result=6; gcd_input_available exactly one pulse.
REQ-035 req_valid=4'b0101 simultaneous, rr_ptr=0 -> requester 0 served first, then 2; rr_ptr=3 after second accept.
REQ-036 All 4 requesters valid continuously -> grant order 0,1,2,3,0; no requester served twice before others.
REQ-037 resp_taken[1] delayed 5 cycles -> resp_valid[1] and result stable 5 cycles, req_ready stays 0, resp_taken[2] pulse ignored.
REQ-038 reset asserted in BUSY -> next cycle IDLE, all outputs 0, no resp_valid; new request (35,14) then returns 7.
REQ-039 Request (0,35): with GCD_ARB_ZERO_BYPASS_EN -> resp_valid next cycle, result 35, no gcd_input_available; without -> via GCD, result 35.
